// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
//   Definitions shared by the serial parity transmitter and receiver.
//   - FSM state encodings (IDLE / DATA / PARITY)
//   - default frame data width
//   - parity mode constants
//   - parity check helper
// -----------------------------------------------------------------------------
package serial_link_pkg;

  // FSM state encodings, kept as plain constants so older tools and the
  // transmitter can share the exact same encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Number of data bits per frame unless overridden.
  localparam int unsigned DEFAULT_DATA_WIDTH = 7;

  // Parity modes.
  localparam int unsigned PARITY_EVEN = 0;
  localparam int unsigned PARITY_ODD  = 1;

  // Returns 1 when the received parity bit does not match the accumulated
  // XOR of the data bits under the selected parity mode.
  function automatic logic parity_fails(input logic acc,
                                        input logic parity_bit,
                                        input logic odd_mode);
    return acc ^ parity_bit ^ odd_mode;
  endfunction

endpackage : serial_link_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter. Increments by one on every clock edge where
//   inc_en is high, and sticks at all-ones once reached.
//
// Ports
//   clk     in   1      clock, state changes on posedge
//   rst_n   in   1      asynchronous active-low reset, clears the count
//   inc_en  in   1      increment request for this cycle
//   count   out  WIDTH  current count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: every combinational output gets a default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc_en && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/serial_parity_receiver.sv
// -----------------------------------------------------------------------------
// serial_parity_receiver
//   Downstream stage of the parallel-to-serial parity transmitter. Captures
//   one framed serial word per Start pulse (DATA_WIDTH data bits LSB-first,
//   followed by one parity bit), checks parity, and presents the word with a
//   one-cycle Valid strobe. A saturating counter tracks failed frames.
//
// Parameters
//   DATA_WIDTH  data bits per frame (>= 2)
//   PARITY_ODD  0: even parity, 1: odd parity
//   ERR_W       width of ErrorCount
//
// Ports
//   Clock        in   1           clock, state changes on posedge
//   Resetn       in   1           asynchronous active-low reset
//   Start        in   1           high for one cycle alongside data bit 0
//   serialInput  in   1           serial line: data bits, then parity bit
//   dataOut      out  DATA_WIDTH  last received word, held until next Valid
//   Valid        out  1           one-cycle pulse when dataOut/ParityError update
//   ParityError  out  1           last frame failed parity; held between Valids
//   Busy         out  1           frame in progress (state != IDLE)
//   ErrorCount   out  ERR_W       failed frames since reset, saturating
// -----------------------------------------------------------------------------
module serial_parity_receiver #(
  parameter int unsigned DATA_WIDTH = serial_link_pkg::DEFAULT_DATA_WIDTH,
  parameter int unsigned PARITY_ODD = serial_link_pkg::PARITY_EVEN,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic                  serialInput,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  Valid,
  output logic                  ParityError,
  output logic                  Busy,
  output logic [ERR_W-1:0]      ErrorCount
);

  import serial_link_pkg::*;

  // One extra bit beyond what DATA_WIDTH needs, so the counter can never
  // wrap within a frame.
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Bit counter value on the edge that samples the last data bit.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);

  logic [1:0]            state_q,       state_d;
  logic [DATA_WIDTH-1:0] sr_q,          sr_d;
  logic                  acc_q,         acc_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q,    data_out_d;
  logic                  valid_q,       valid_d;
  logic                  parity_err_q,  parity_err_d;
  logic                  err_inc;

  // Incoming bits enter at the MSB and move toward the LSB, so after
  // DATA_WIDTH shifts bit 0 of the word sits at sr[0].
  logic [DATA_WIDTH-1:0] sr_shifted;
  assign sr_shifted = {serialInput, sr_q[DATA_WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    err_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          sr_d    = sr_shifted;
          acc_d   = serialInput;
          cnt_d   = CNT_ONE;
          state_d = ST_DATA;
        end
      end

      // Start is not looked at here or in PARITY: a new Start pulse during
      // a frame is ignored and the frame completes normally.
      ST_DATA: begin
        sr_d  = sr_shifted;
        acc_d = acc_q ^ serialInput;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_PARITY;
        end
      end

      ST_PARITY: begin
        data_out_d   = sr_q;
        valid_d      = 1'b1;
        parity_err_d = parity_fails(acc_q, serialInput, ODD_BIT);
        err_inc      = parity_err_d;
        cnt_d        = '0;
        state_d      = ST_IDLE;
      end

      // Unused encoding: recover to IDLE without producing a Valid.
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: every register here, including the shift register, is cleared by
  // reset; a frame interrupted by reset is discarded and leaves no residue.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_counter (
    .clk    (Clock),
    .rst_n  (Resetn),
    .inc_en (err_inc),
    .count  (ErrorCount)
  );

  assign dataOut     = data_out_q;
  assign Valid       = valid_q;
  assign ParityError = parity_err_q;
  assign Busy        = (state_q != ST_IDLE);

endmodule : serial_parity_receiver

// File: tb/tb_serial_parity_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_receiver
//   Two receivers (even and odd parity) share one serial line. Inputs change
//   on the falling edge, outputs are sampled on the falling edge, i.e. half a
//   cycle after the rising edge that produced them. The reference model works
//   at frame level: expected word, parity outcome from the XOR of the data
//   bits, and a saturating integer count of bad frames per receiver.
// -----------------------------------------------------------------------------
module tb_serial_parity_receiver;

  localparam int DW      = 7;
  localparam int EW      = 8;
  localparam int CNT_MAX = (1 << EW) - 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ser_in;

  logic [DW-1:0] e_data;
  logic          e_valid;
  logic          e_perr;
  logic          e_busy;
  logic [EW-1:0] e_cnt;

  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_perr;
  logic          o_busy;
  logic [EW-1:0] o_cnt;

  serial_parity_receiver #(
    .DATA_WIDTH (DW),
    .PARITY_ODD (0),
    .ERR_W      (EW)
  ) u_dut_even (
    .Clock       (clk),
    .Resetn      (rst_n),
    .Start       (start),
    .serialInput (ser_in),
    .dataOut     (e_data),
    .Valid       (e_valid),
    .ParityError (e_perr),
    .Busy        (e_busy),
    .ErrorCount  (e_cnt)
  );

  serial_parity_receiver #(
    .DATA_WIDTH (DW),
    .PARITY_ODD (1),
    .ERR_W      (EW)
  ) u_dut_odd (
    .Clock       (clk),
    .Resetn      (rst_n),
    .Start       (start),
    .serialInput (ser_in),
    .dataOut     (o_data),
    .Valid       (o_valid),
    .ParityError (o_perr),
    .Busy        (o_busy),
    .ErrorCount  (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model state.
  logic [DW-1:0] m_data;
  logic          m_perr_e;
  logic          m_perr_o;
  int            m_cnt_e;
  int            m_cnt_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit period; returns at the next falling edge, after the DUT
  // has sampled these inputs on the rising edge in between.
  task automatic tick(input logic s, input logic b);
    start  = s;
    ser_in = b;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_data   = '0;
    m_perr_e = 1'b0;
    m_perr_o = 1'b0;
    m_cnt_e  = 0;
    m_cnt_o  = 0;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_data_e"}, e_data, m_data);
    check({tag, "_data_o"}, o_data, m_data);
    check({tag, "_perr_e"}, e_perr, m_perr_e);
    check({tag, "_perr_o"}, o_perr, m_perr_o);
    check({tag, "_cnt_e"},  e_cnt,  m_cnt_e);
    check({tag, "_cnt_o"},  o_cnt,  m_cnt_o);
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'($urandom));
    check("idle_valid_e", e_valid, 1'b0);
    check("idle_valid_o", o_valid, 1'b0);
    check("idle_busy_e",  e_busy,  1'b0);
    check("idle_busy_o",  o_busy,  1'b0);
    check_held("idle");
  endtask

  // Send one frame. restart_at in 1..DW-1 re-pulses Start on that data bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input int restart_at);
    logic ones;
    for (int i = 0; i < DW; i++) begin
      tick((i == 0) || (i == restart_at), d[i]);
      check("bit_valid_e", e_valid, 1'b0);
      check("bit_valid_o", o_valid, 1'b0);
      check("bit_busy_e",  e_busy,  1'b1);
      check("bit_busy_o",  o_busy,  1'b1);
      check_held("bit");
    end
    tick(1'b0, p);
    // Even parity: parity bit equals XOR of data; odd parity: its inverse.
    ones     = ^d;
    m_data   = d;
    m_perr_e = (ones != p);
    m_perr_o = (ones == p);
    if (m_perr_e && m_cnt_e < CNT_MAX) m_cnt_e++;
    if (m_perr_o && m_cnt_o < CNT_MAX) m_cnt_o++;
    check("end_valid_e", e_valid, 1'b1);
    check("end_valid_o", o_valid, 1'b1);
    check("end_busy_e",  e_busy,  1'b0);
    check("end_busy_o",  o_busy,  1'b0);
    check_held("end");
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst_n  = 1'b0;
    start  = 1'b0;
    ser_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_valid", e_valid, 1'b0);
    check("rst_busy",  e_busy,  1'b0);
    check_held("rst");
    rst_n = 1'b1;
    idle_tick();

    // Case 1: 0x55 with correct even parity.
    send_frame(7'h55, 1'b0, -1);
    check("c1_data", e_data, 7'h55);
    check("c1_perr", e_perr, 1'b0);
    check("c1_cnt",  e_cnt,  8'd0);
    idle_tick();

    // Case 2: 0x01 with wrong even parity; error holds until next Valid.
    send_frame(7'h01, 1'b0, -1);
    check("c2_perr", e_perr, 1'b1);
    check("c2_cnt",  e_cnt,  8'd1);
    repeat (3) idle_tick();
    check("c2_perr_hold", e_perr, 1'b1);

    // Case 3: back-to-back frames, second Start on the Valid cycle.
    send_frame(7'h7F, 1'b1, -1);
    send_frame(7'h00, 1'b0, -1);
    check("c3_data", e_data, 7'h00);
    idle_tick();

    // Case 4: reset asserted after E3 of a frame; frame discarded.
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) tick(1'b0, 1'($urandom));
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("c4_async_busy",  e_busy,  1'b0);
    check("c4_async_valid", e_valid, 1'b0);
    check_held("c4_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DW + 2; i++) idle_tick();
    send_frame(7'h2A, 1'b1, -1);
    check("c4_data", e_data, 7'h2A);
    check("c4_perr", e_perr, 1'b0);

    // Case 5: Start re-pulsed at E3 is ignored.
    send_frame(7'h12, 1'b0, 3);
    check("c5_data", e_data, 7'h12);
    idle_tick();

    // Randomised frames with random gaps and stray Start pulses.
    for (int n = 0; n < 40; n++) begin
      rd = DW'($urandom);
      send_frame(rd, 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW - 1)) : -1);
      repeat ($urandom_range(0, 2)) idle_tick();
    end

    // Case 6: enough bad even-parity frames to saturate the even counter.
    for (int n = 0; n < CNT_MAX + 4; n++) begin
      rd = DW'($urandom);
      send_frame(rd, ~(^rd), -1);
    end
    check("c6_sat", e_cnt, 8'hFF);
    idle_tick();

    // Odd parity: 0x55 with parity bit 1 is good on the odd receiver.
    send_frame(7'h55, 1'b1, -1);
    check("c6_odd_perr",  o_perr, 1'b0);
    check("c6_even_perr", e_perr, 1'b1);
    check("c6_sat_hold",  e_cnt,  8'hFF);
    idle_tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_parity_receiver
